// File: rtl/load_store_unit.sv
// load_store_unit
//   Core-side initiator for a word-organised data memory (sync write,
//   async read, byte addressing). Accepts RV32I loads and stores
//   (LB/LH/LW/LBU/LHU/SB/SH/SW) and drives a word-only memory port.
//   Sub-word stores are a read-modify-write. Load data is extracted and
//   sign/zero-extended. Memory read data is registered inside the unit.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_we, req_funct3         store flag and RV32I funct3
//   req_addr, req_wdata        byte address and store data
//   resp_valid                 one-cycle completion pulse
//   resp_rdata, resp_err       extended load data / misaligned-or-illegal flag
//   mem_we, mem_addr, mem_wd   memory write enable, aligned address, write data
//   mem_rd                     memory read data (combinational from mem_addr)
module load_store_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t           state, state_next;
    logic             we_q;
    logic             err_q;
    logic [2:0]       funct3_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] rdata_q;

    logic             req_err;
    logic [WIDTH-1:0] rd_shifted;
    logic [15:0]      rd_half;
    logic [WIDTH-1:0] load_value;

    // Decode misalignment / illegal funct3 straight from the request so the
    // accept edge can already branch to RESP.
    always_comb begin
        req_err = 1'b0;
        if (req_we) begin
            case (req_funct3)
                3'b000:  req_err = 1'b0;
                3'b001:  req_err = req_addr[0];
                3'b010:  req_err = |req_addr[1:0];
                default: req_err = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b100: req_err = 1'b0;
                3'b001, 3'b101: req_err = req_addr[0];
                3'b010:         req_err = |req_addr[1:0];
                default:        req_err = 1'b1;
            endcase
        end
    end

    // Lane extraction works on the live memory word during RD; the result is
    // registered so RESP presents it without any path back to the memory.
    always_comb begin
        rd_shifted = mem_rd >> {addr_q[1:0], 3'b000};
        rd_half    = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (funct3_q)
            3'b000:  load_value = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            3'b001:  load_value = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_value = {24'h0, rd_shifted[7:0]};
            3'b101:  load_value = {16'h0, rd_half};
            default: load_value = mem_rd;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and the state-decoded outputs. mem_we and resp_* derive
    // only from the state, so an async reset drops them immediately.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        mem_we     = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err) begin
                        state_next = RESP;
                    end else if (req_we && req_funct3 == 3'b010) begin
                        state_next = WR;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD: begin
                state_next = we_q ? WR : RESP;
            end
            WR: begin
                mem_we     = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = rdata_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latch on accept, memory word capture on leaving RD. rdata_q is
    // cleared on accept so stores and errors respond with zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            word_q   <= '0;
            rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        err_q    <= req_err;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        rdata_q  <= '0;
                    end
                end
                RD: begin
                    word_q <= mem_rd;
                    if (!we_q) begin
                        rdata_q <= load_value;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr = {addr_q[WIDTH-1:2], 2'b00};

    // Merge store data into the captured word; only the target lane(s) change.
    always_comb begin
        mem_wd = '0;
        if (state == WR) begin
            case (funct3_q)
                3'b000: begin
                    mem_wd = word_q;
                    case (addr_q[1:0])
                        2'd0:    mem_wd[7:0]   = wdata_q[7:0];
                        2'd1:    mem_wd[15:8]  = wdata_q[7:0];
                        2'd2:    mem_wd[23:16] = wdata_q[7:0];
                        default: mem_wd[31:24] = wdata_q[7:0];
                    endcase
                end
                3'b001: begin
                    mem_wd = word_q;
                    if (addr_q[1]) begin
                        mem_wd[31:16] = wdata_q[15:0];
                    end else begin
                        mem_wd[15:0] = wdata_q[15:0];
                    end
                end
                default: mem_wd = wdata_q;
            endcase
        end
    end

endmodule
